// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//
// Multi-cycle ALU that sits between operand fetch and writeback.
// - Operands and the op code are accepted through a valid/ready handshake.
// - AND, OR, ADD and SUB finish in one cycle.
// - MUL uses shift-add and DIV uses restoring division. Each retires one bit
//   per cycle.
// - The result is held on a second valid/ready handshake until the consumer
//   takes it.
//
// Optional feature macro: SEQ_ALU_MULHI_EN
//   When defined, the block adds a result_hi output. It carries the upper half
//   of the MUL product. When undefined, the upper half only forms overflow.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand/op presented
//   in_ready     block can accept (IDLE only)
//   ALU_ctrl     op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 MUL, 0100 DIV
//   input1       operand A / dividend
//   input2       operand B / divisor
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts the result
//   result       result / low product / quotient
//   r            remainder (DIV only, else 0)
//   zero         result == 0, meaningful while out_valid is high
//   overflow     signed add/sub overflow, or nonzero upper MUL product
//   div_by_zero  DIV with input2 == 0
//   illegal_op   unsupported ALU_ctrl code
//   result_hi    upper MUL product half (SEQ_ALU_MULHI_EN only)
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter  int WIDTH = 64,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALU_ctrl,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] r,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal_op
`ifdef SEQ_ALU_MULHI_EN
   ,
   output logic [WIDTH-1:0] result_hi
`endif
);

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpMul = 4'b0111;
   localparam logic [3:0] OpDiv = 4'b0100;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

   stateT            state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] accHi_q,    accHi_d;
   logic [WIDTH-1:0] accLo_q,    accLo_d;
   logic [WIDTH-1:0] operand_q,  operand_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic [WIDTH-1:0] rem_q,      rem_d;
   logic             zero_q,     zero_d;
   logic             ovf_q,      ovf_d;
   logic             divZero_q,  divZero_d;
   logic             illOp_q,    illOp_d;
`ifdef SEQ_ALU_MULHI_EN
   logic [WIDTH-1:0] resultHi_q, resultHi_d;
`endif

   logic [WIDTH-1:0] addRes;
   logic [WIDTH-1:0] subRes;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH-1:0] mulHiNext;
   logic [WIDTH-1:0] mulLoNext;
   logic [WIDTH:0]   divShift;
   logic [WIDTH:0]   divTrial;
   logic             divFits;
   logic [WIDTH-1:0] divRemNext;
   logic [WIDTH-1:0] divQuoNext;
   logic             finishing;

   // Next-state and datapath logic.
   // accHi/accLo form one double-width shift register that both iterative ops
   // share:
   // - MUL shifts right. The multiplier leaves from the bottom of accLo and
   //   product bits enter at the top.
   // - DIV shifts left. The dividend leaves from the top of accLo into the
   //   partial remainder in accHi, and quotient bits enter at the bottom.
   // An op finishes on the edge where the counter goes from 1 to 0. Its
   // results are therefore taken from this cycle's post-iteration values.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accHi_d    = accHi_q;
      accLo_d    = accLo_q;
      operand_d  = operand_q;
      result_d   = result_q;
      rem_d      = rem_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      divZero_d  = divZero_q;
      illOp_d    = illOp_q;
`ifdef SEQ_ALU_MULHI_EN
      resultHi_d = resultHi_q;
`endif
      finishing  = 1'b0;

      addRes     = input1 + input2;
      subRes     = input1 - input2;
      mulSum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operand_q} : '0);
      mulHiNext  = mulSum[WIDTH:1];
      mulLoNext  = {mulSum[0], accLo_q[WIDTH-1:1]};
      divShift   = {accHi_q, accLo_q[WIDTH-1]};
      divTrial   = divShift - {1'b0, operand_q};
      divFits    = ~divTrial[WIDTH];
      divRemNext = divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
      divQuoNext = {accLo_q[WIDTH-2:0], divFits};

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               rem_d     = '0;
               ovf_d     = 1'b0;
               divZero_d = 1'b0;
               illOp_d   = 1'b0;
`ifdef SEQ_ALU_MULHI_EN
               resultHi_d = '0;
`endif
               case (ALU_ctrl)
                  OpAnd: begin
                     result_d  = input1 & input2;
                     finishing = 1'b1;
                  end
                  OpOr: begin
                     result_d  = input1 | input2;
                     finishing = 1'b1;
                  end
                  OpAdd: begin
                     result_d  = addRes;
                     ovf_d     = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                                 (addRes[WIDTH-1] != input1[WIDTH-1]);
                     finishing = 1'b1;
                  end
                  OpSub: begin
                     result_d  = subRes;
                     ovf_d     = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                                 (subRes[WIDTH-1] != input1[WIDTH-1]);
                     finishing = 1'b1;
                  end
                  OpMul: begin
                     accHi_d   = '0;
                     accLo_d   = input1;
                     operand_d = input2;
                     cnt_d     = CNT_W'(WIDTH);
                     state_d   = MUL;
                  end
                  OpDiv: begin
                     if (input2 == '0) begin
                        result_d  = '1;
                        rem_d     = input1;
                        divZero_d = 1'b1;
                        finishing = 1'b1;
                     end else begin
                        accHi_d   = '0;
                        accLo_d   = input1;
                        operand_d = input2;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = DIV;
                     end
                  end
                  default: begin
                     result_d  = '0;
                     illOp_d   = 1'b1;
                     finishing = 1'b1;
                  end
               endcase
            end
         end
         MUL: begin
            accHi_d = mulHiNext;
            accLo_d = mulLoNext;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d  = mulLoNext;
               ovf_d     = |mulHiNext;
`ifdef SEQ_ALU_MULHI_EN
               resultHi_d = mulHiNext;
`else
               // The upper product half only feeds overflow in this build.
`endif
               finishing = 1'b1;
            end
         end
         DIV: begin
            accHi_d = divRemNext;
            accLo_d = divQuoNext;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d  = divQuoNext;
               rem_d     = divRemNext;
               finishing = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // zero is only refreshed when a result is produced. Outputs held in
      // DONE therefore never change under the consumer.
      if (finishing) begin
         state_d = DONE;
         zero_d  = (result_d == '0);
      end
   end

   // State and result registers.
   // Reset clears everything, so an abandoned op leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         accHi_q    <= '0;
         accLo_q    <= '0;
         operand_q  <= '0;
         result_q   <= '0;
         rem_q      <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         divZero_q  <= 1'b0;
         illOp_q    <= 1'b0;
`ifdef SEQ_ALU_MULHI_EN
         resultHi_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         accHi_q    <= accHi_d;
         accLo_q    <= accLo_d;
         operand_q  <= operand_d;
         result_q   <= result_d;
         rem_q      <= rem_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         divZero_q  <= divZero_d;
         illOp_q    <= illOp_d;
`ifdef SEQ_ALU_MULHI_EN
         resultHi_q <= resultHi_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign r           = rem_q;
   assign zero        = zero_q;
   assign overflow    = ovf_q;
   assign div_by_zero = divZero_q;
   assign illegal_op  = illOp_q;
`ifdef SEQ_ALU_MULHI_EN
   assign result_hi   = resultHi_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
//
// Scoreboard bench for seq_alu (WIDTH = 64).
// - The stimulus process issues directed ops and pushes hand-computed
//   expectations into a queue.
// - The monitor pops the queue and compares on every output handshake.
// - The monitor also checks the accept-to-out_valid latency.
// ---------------------------------------------------------------------------
module tb_seq_alu;

   localparam int W = 64;

   localparam logic [3:0] OpAnd = 4'b0000;
   localparam logic [3:0] OpOr  = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpMul = 4'b0111;
   localparam logic [3:0] OpDiv = 4'b0100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   ALU_ctrl;
   logic [W-1:0] input1;
   logic [W-1:0] input2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] r;
   logic         zero;
   logic         overflow;
   logic         div_by_zero;
   logic         illegal_op;
`ifdef SEQ_ALU_MULHI_EN
   logic [W-1:0] result_hi;
`endif

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic [W-1:0] rem;
      logic [W-1:0] hi;
      logic         zero;
      logic         ovf;
      logic         dbz;
      logic         ill;
      int           lat;
      int           acceptCycle;
   } expT;

   expT sb[$];
   int  checks     = 0;
   int  failures   = 0;
   int  cycleCount = 0;
   bit  seenValid  = 1'b0;

   seq_alu #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALU_ctrl   (ALU_ctrl),
      .input1     (input1),
      .input2     (input2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .r          (r),
      .zero       (zero),
      .overflow   (overflow),
      .div_by_zero(div_by_zero),
      .illegal_op (illegal_op)
`ifdef SEQ_ALU_MULHI_EN
      ,
      .result_hi  (result_hi)
`endif
   );

   // Free-running clock and a cycle counter for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare one completed transaction against its scoreboard entry.
   task automatic checkOutput(input expT e);
      checkVal({e.name, " result"},      result, e.res);
      checkVal({e.name, " r"},           r, e.rem);
      checkVal({e.name, " zero"},        W'(zero), W'(e.zero));
      checkVal({e.name, " overflow"},    W'(overflow), W'(e.ovf));
      checkVal({e.name, " div_by_zero"}, W'(div_by_zero), W'(e.dbz));
      checkVal({e.name, " illegal_op"},  W'(illegal_op), W'(e.ill));
`ifdef SEQ_ALU_MULHI_EN
      checkVal({e.name, " result_hi"},   result_hi, e.hi);
`endif
   endtask

   // Monitor: samples on the falling edge.
   // - Checks latency the first time out_valid appears for the head entry.
   // - Pops and compares on the output handshake.
   // - Flags any out_valid that has no expectation behind it.
   always @(negedge clk) begin
      if (!rst_n) begin
         seenValid = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected out_valid: got result 0x%0h expected no output", result);
         end else begin
            if (!seenValid) begin
               seenValid = 1'b1;
               checkVal({sb[0].name, " latency"},
                        W'(cycleCount - sb[0].acceptCycle + 1), W'(sb[0].lat));
            end
            if (out_ready) begin
               checkOutput(sb.pop_front());
               seenValid = 1'b0;
            end
         end
      end
   end

   // Present an op until it is accepted, then scramble the inputs so that any
   // failure to latch them shows up in the result.
   task automatic issueOp(input string name, input logic [3:0] ctrl,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expRes, input logic [W-1:0] expRem,
                          input logic [W-1:0] expHi, input logic expZero,
                          input logic expOvf, input logic expDbz,
                          input logic expIll, input int expLat);
      expT e;
      bit  accepted;
      int  tries;
      e.name = name;  e.res = expRes; e.rem = expRem; e.hi = expHi;
      e.zero = expZero; e.ovf = expOvf; e.dbz = expDbz; e.ill = expIll;
      e.lat  = expLat; e.acceptCycle = 0;
      ALU_ctrl = ctrl;
      input1   = a;
      input2   = b;
      in_valid = 1'b1;
      accepted = 1'b0;
      tries    = 0;
      while (!accepted && tries < 100) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
         tries++;
      end
      in_valid = 1'b0;
      ALU_ctrl = OpOr;
      input1   = ~a;
      input2   = ~b;
      checks++;
      if (accepted) begin
         e.acceptCycle = cycleCount;
         sb.push_back(e);
      end else begin
         failures++;
         $display("[TB] FAIL %s accept: got in_ready 0 for 100 cycles expected accept", name);
      end
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s drain: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic applyStimulus(input string name, input logic [3:0] ctrl,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] expRes, input logic [W-1:0] expRem,
                                input logic [W-1:0] expHi, input logic expZero,
                                input logic expOvf, input logic expDbz,
                                input logic expIll, input int expLat);
      issueOp(name, ctrl, a, b, expRes, expRem, expHi, expZero, expOvf, expDbz, expIll, expLat);
      waitDrain(name);
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, " out_valid"},   W'(out_valid), '0);
      checkVal({tag, " result"},      result, '0);
      checkVal({tag, " r"},           r, '0);
      checkVal({tag, " zero"},        W'(zero), '0);
      checkVal({tag, " overflow"},    W'(overflow), '0);
      checkVal({tag, " div_by_zero"}, W'(div_by_zero), '0);
      checkVal({tag, " illegal_op"},  W'(illegal_op), '0);
      checkVal({tag, " in_ready"},    W'(in_ready), W'(1));
   endtask

   // Watchdog so the bench always ends.
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ALU_ctrl  = '0;
      input1    = '0;
      input2    = '0;
      #2 rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("ADD 100+200", OpAdd, 64'd100, 64'd200, 64'd300, '0, '0, 0, 0, 0, 0, 1);
      applyStimulus("SUB 100-200", OpSub, 64'd100, 64'd200, 64'hFFFF_FFFF_FFFF_FF9C, '0, '0, 0, 0, 0, 0, 1);
      applyStimulus("SUB 10-10", OpSub, 64'd10, 64'd10, '0, '0, '0, 1, 0, 0, 0, 1);
      applyStimulus("ADD max+1", OpAdd, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                    64'h8000_0000_0000_0000, '0, '0, 0, 1, 0, 0, 1);
      applyStimulus("SUB min-1", OpSub, 64'h8000_0000_0000_0000, 64'd1,
                    64'h7FFF_FFFF_FFFF_FFFF, '0, '0, 0, 1, 0, 0, 1);
      applyStimulus("AND", OpAnd, 64'hF0F0, 64'hFF00, 64'hF000, '0, '0, 0, 0, 0, 0, 1);
      applyStimulus("OR", OpOr, 64'hF0F0, 64'hFF00, 64'hFFF0, '0, '0, 0, 0, 0, 0, 1);
      applyStimulus("MUL 10*20", OpMul, 64'd10, 64'd20, 64'd200, '0, '0, 0, 0, 0, 0, W + 1);
      applyStimulus("MUL 2^63*2", OpMul, 64'h8000_0000_0000_0000, 64'd2, '0, '0, 64'd1, 1, 1, 0, 0, W + 1);
      applyStimulus("MUL max*3", OpMul, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                    64'hFFFF_FFFF_FFFF_FFFD, '0, 64'd2, 0, 1, 0, 0, W + 1);
      applyStimulus("DIV 10/20", OpDiv, 64'd10, 64'd20, '0, 64'd10, '0, 1, 0, 0, 0, W + 1);
      applyStimulus("DIV 200/7", OpDiv, 64'd200, 64'd7, 64'd28, 64'd4, '0, 0, 0, 0, 0, W + 1);
      applyStimulus("DIV max/16", OpDiv, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                    64'h0FFF_FFFF_FFFF_FFFF, 64'hF, '0, 0, 0, 0, 0, W + 1);
      applyStimulus("DIV 5/0", OpDiv, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, '0, 0, 0, 1, 0, 1);

      // Backpressure: hold the result for 10 cycles while a new op knocks.
      out_ready = 1'b0;
      issueOp("BP ADD 1+2", OpAdd, 64'd1, 64'd2, 64'd3, '0, '0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            ALU_ctrl = OpMul;
            input1   = 64'd5;
            input2   = 64'd6;
         end
         @(negedge clk);
         checkVal("BP in_ready",  W'(in_ready), '0);
         checkVal("BP out_valid", W'(out_valid), W'(1));
         checkVal("BP result",    result, 64'd3);
         checkVal("BP zero",      W'(zero), '0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkVal("BP release out_valid", W'(out_valid), '0);
      checkVal("BP release in_ready",  W'(in_ready), W'(1));
      waitDrain("BP ADD 1+2");

      // Reset in the middle of a multiply abandons it.
      issueOp("RST MUL", OpMul, 64'd10, 64'd20, 64'd200, '0, '0, 0, 0, 0, 0, W + 1);
      repeat (29) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid-op reset");
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkVal("post-reset out_valid", W'(out_valid), '0);
         checkVal("post-reset in_ready",  W'(in_ready), W'(1));
      end
      @(posedge clk);
      #1;
      applyStimulus("ILLEGAL 1111", 4'b1111, 64'd7, 64'd9, '0, '0, '0, 1, 0, 0, 1, 1);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
